uart_rx_os: RTL and testbench

Oversampling UART receiver running directly on the system clock, the receive-side counterpart to the team's baud-clocked transmit path. It synchronises the asynchronous `rx` line, detects and validates the start bit, and samples each bit at mid-period using a 16× tick. It delivers 8N1 bytes through a valid/ack holding register and flags framing and overrun errors. It sits between the board's RX pin and the byte consumer (keyboard/command decoder), replacing the divided-clock receive path.

---
 rtl/uart_rx_os.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_os.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
`timescale 1ns/1ps
// uart_rx_os: 16x oversampling 8N1 UART receiver on the system clock.
// Synchronises rx, validates the start bit at mid-bit, samples each data bit at
// mid-period, and hands bytes to the consumer through a valid/ack holding register.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   rx         asynchronous serial line, idles high
//   rx_data    received byte, stable while rx_valid is high
//   rx_valid   holding register full until rx_ack
//   rx_ack     consumer acknowledge, clears rx_valid and overrun
//   frame_err  one-cycle pulse when the stop bit samples low
//   overrun    sticky, a byte completed while rx_valid was still high
//   busy       receiver is not idle
module uart_rx_os #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OS       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DivRaw = CLK_FREQ / (BAUD * OS);
  localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
  localparam int unsigned TickW  = $clog2(Div) + 1;
  localparam logic [TickW-1:0] TickMax = TickW'(Div - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rxs_q;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [3:0]       os_cnt_q, os_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  // Free-running tick; start detection is not phase-aligned to it, and the
  // mid-bit sampling point absorbs up to one tick of that error.
  assign tick       = (tick_cnt_q == TickMax);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx;
      rxs_q       <= rx_meta_q;
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!rxs_q) state_d = StStart;
      end
      StStart: begin
        // Line high again at mid start bit: a glitch, drop it silently.
        if (tick && (os_cnt_q == 4'd7)) state_d = rxs_q ? StIdle : StData;
      end
      StData: begin
        if (tick && (os_cnt_q == 4'd15) && (bit_cnt_q == 3'd7)) state_d = StStop;
      end
      StStop: begin
        if (tick && (os_cnt_q == 4'd15)) state_d = rxs_q ? StIdle : StBreak;
      end
      StBreak: begin
        // Hold here until the line recovers so a stuck-low line is not re-read.
        if (rxs_q) state_d = StBreak == state_q ? StIdle : state_q;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters, shift register and holding register.
  always_comb begin
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;

    if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end

    case (state_q)
      StIdle: begin
        os_cnt_d = '0;
      end
      StStart: begin
        if (tick) begin
          if (os_cnt_q == 4'd7) begin
            os_cnt_d  = '0;
            bit_cnt_d = '0;
          end else begin
            os_cnt_d = os_cnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;  // wraps 15 -> 0 at each bit boundary
          if (os_cnt_q == 4'd15) begin
            sh_d = {rxs_q, sh_q[7:1]};
            if (bit_cnt_q != 3'd7) bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 4'd1;
          if (os_cnt_q == 4'd15) begin
            if (rxs_q) begin
              // Completion overrides a same-cycle ack; newest byte always wins.
              rx_data_d  = sh_q;
              rx_valid_d = 1'b1;
              if (rx_valid_q && !rx_ack) overrun_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    rx_data   = rx_data_q;
    rx_valid  = rx_valid_q;
    overrun   = overrun_q;
    frame_err = frame_err_q;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_os at DIV = 2 (32 clocks per bit).
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err) fe_cnt <= fe_cnt + 1;

  uart_rx_os #(
    .CLK_FREQ(3_200_000),
    .BAUD    (100_000),
    .OS      (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  // All senders start and end on a falling clock edge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (32) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_nominal();
    int  k;
    int  fe0;
    bit  seen;
    fe0  = fe_cnt;
    k    = 0;
    seen = 1'b0;
    fork
      send_byte(8'hA5);
      begin
        while (k < 320 && !seen) begin
          @(negedge clk);
          k++;
          if (rx_valid) seen = 1'b1;
        end
      end
    join
    checks++;
    if (!seen || k > 311) begin
      errors++; $display("FAIL nominal_latency: got %0d clocks (seen=%b) want <= 311", k, seen);
    end
    checks++;
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL nominal_data: got %h want a5", rx_data); end
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL nominal_valid: got %b want 1", rx_valid); end
    checks++;
    if (fe_cnt - fe0 != 0) begin
      errors++; $display("FAIL nominal_ferr: got %0d pulses want 0", fe_cnt - fe0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy: got %b want 0", busy); end
    ack_pulse();
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL nominal_ack: got %b want 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h00);
    checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got data %h valid %b want 00/1", rx_data, rx_valid);
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr: got %b want 0", overrun); end
    send_byte(8'hFF);
    checks++;
    if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %h want ff", rx_data); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", rx_valid); end
    ack_pulse();
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack_valid: got %b want 0", rx_valid); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ack_ovr: got %b want 0", overrun); end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    int         fe0;
    d   = 8'h3C;
    fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(1'b0);
    send_bit(1'b0);
    checks++;
    if (fe_cnt - fe0 != 1) begin
      errors++; $display("FAIL ferr_pulse: got %0d pulses want 1", fe_cnt - fe0);
    end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b want 0", rx_valid); end
    checks++;
    if (rx_data !== 8'hFF) begin errors++; $display("FAIL ferr_data_kept: got %h want ff", rx_data); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ferr_break_busy: got %b want 1", busy); end
    rx = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ferr_idle: got %b want 0", busy); end
    send_byte(8'h55);
    checks++;
    if (rx_data !== 8'h55 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL ferr_next: got data %h valid %b want 55/1", rx_data, rx_valid);
    end
    checks++;
    if (fe_cnt - fe0 != 1) begin
      errors++; $display("FAIL ferr_next_pulse: got %0d pulses want 1", fe_cnt - fe0);
    end
    ack_pulse();
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    rx  = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start: got busy %b want 1", busy); end
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b want 0", busy); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    checks++;
    if (fe_cnt - fe0 != 0) begin
      errors++; $display("FAIL glitch_ferr: got %0d pulses want 0", fe_cnt - fe0);
    end
    repeat (40) @(negedge clk);
  endtask

  // The second frame starts an even number of clocks after the first, so its
  // completion lands at the same offset (tick phase repeats every 2 clocks).
  task automatic test_collision();
    int k;
    int d;
    bit seen;
    k    = 0;
    d    = 0;
    seen = 1'b0;
    fork
      begin
        send_byte(8'h12);
        send_byte(8'h34);
      end
      begin
        while (k < 330 && !seen) begin
          @(negedge clk);
          k++;
          if (rx_valid) seen = 1'b1;
        end
        d = k;
        checks++;
        if (!seen || rx_data !== 8'h12) begin
          errors++; $display("FAIL coll_first: got data %h seen %b want 12/1", rx_data, seen);
        end
        if (seen) begin
          while (k < 320 + d - 1) begin
            @(negedge clk);
            k++;
          end
          ack_pulse();
          checks++;
          if (rx_valid !== 1'b1) begin
            errors++; $display("FAIL coll_valid: got %b want 1", rx_valid);
          end
          checks++;
          if (rx_data !== 8'h34) begin
            errors++; $display("FAIL coll_data: got %h want 34", rx_data);
          end
          checks++;
          if (overrun !== 1'b0) begin
            errors++; $display("FAIL coll_overrun: got %b want 0", overrun);
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    // Holding register is full (0x34) entering this test, so reset is visible.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", rx_valid); end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h want 00", rx_data); end
    checks++;
    if (overrun !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL mid_rst_flags: got ovr %b ferr %b want 0/0", overrun, frame_err);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    repeat (200) @(negedge clk);
    fe0 = fe_cnt;
    send_byte(8'h81);
    checks++;
    if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL mid_rst_next: got data %h valid %b want 81/1", rx_data, rx_valid);
    end
    checks++;
    if (overrun !== 1'b0 || fe_cnt - fe0 != 0) begin
      errors++; $display("FAIL mid_rst_next_flags: got ovr %b ferr %0d want 0/0", overrun,
                         fe_cnt - fe0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_nominal();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_collision();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded 2 ms limit");
    $fatal(1, "timeout");
  end

endmodule
